// File: rtl/fetch_seq_pkg.sv
// ---------------------------------------------------------------------------
// fetch_seq_pkg
// Shared types and default sizes for the fetch sequencer slice.
//   seq_state_e : run-controller states (IDLE, LOAD, RUN, DONE, FAULT)
//   br_op_e     : decoded branch-type encoding carried on BrOp
//   DEFAULT_*   : default program-counter, counter and watchdog sizes
// ---------------------------------------------------------------------------
package fetch_seq_pkg;

    localparam int DEFAULT_PW         = 10;
    localparam int DEFAULT_CW         = 16;
    localparam int DEFAULT_MAX_CYCLES = 1023;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        DONE  = 3'd3,
        FAULT = 3'd4
    } seq_state_e;

    typedef enum logic [1:0] {
        BR_NONE       = 2'b00,
        BR_ABS        = 2'b01,
        BR_REL_COND   = 2'b10,
        BR_REL_UNCOND = 2'b11
    } br_op_e;

endpackage

// File: rtl/run_watchdog.sv
// ---------------------------------------------------------------------------
// run_watchdog
// Cycle counter that limits how long a program may stay in RUN.
//   clk, rst : clock and asynchronous active-high reset
//   clr      : synchronous clear (takes priority over en)
//   en       : count this cycle
//   tc       : count has reached MAX_CYCLES-1
// The counter saturates at all-ones so it can never wrap back under the
// terminal value.
// ---------------------------------------------------------------------------
module run_watchdog #(
    parameter int CW         = 16,
    parameter int MAX_CYCLES = 1023
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [CW-1:0] TC_VALUE = CW'(MAX_CYCLES - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: clear wins, otherwise step while enabled and not saturated.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = (count_q == TC_VALUE);

endmodule

// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
// Program-run controller for the instruction fetch unit. Turns a Start
// request into a one-cycle FetchStart, gates decoded branches onto the
// fetch-unit controls, inserts a one-cycle Flush bubble after each taken
// branch and ends the run on Halt (Done) or watchdog expiry (Timeout).
//
// Ports:
//   Clk, Reset   : clock, asynchronous active-high reset
//   Start        : run request, honoured in IDLE/DONE/FAULT
//   Halt         : decoded halt at the current PC
//   BrOp         : branch type (see br_op_e)
//   CondFlag     : ALU condition for relative-conditional branches
//   BrOffset     : absolute target or relative offset
//   FetchStart   : fetch-unit start (PC <- 0), one cycle in LOAD
//   BranchAbs    : fetch-unit absolute branch
//   BranchRelEn  : fetch-unit relative branch enable
//   ALU_flag     : fetch-unit relative-branch qualifier
//   Target       : fetch-unit target/offset
//   Flush        : current instruction is a bubble
//   Running      : state is RUN
//   Done         : sticky normal completion
//   Timeout      : sticky watchdog fault
//   RetireCnt    : retired (non-flushed) RUN instructions
//
// Optional feature macro: RETIRE_COUNT_EN
//   defined   -> RetireCnt counts active RUN cycles (saturating)
//   undefined -> RetireCnt is tied to 0
// ---------------------------------------------------------------------------
module fetch_sequencer
    import fetch_seq_pkg::*;
#(
    parameter int PW         = DEFAULT_PW,
    parameter int MAX_CYCLES = DEFAULT_MAX_CYCLES,
    parameter int CW         = DEFAULT_CW
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic          Halt,
    input  logic [1:0]    BrOp,
    input  logic          CondFlag,
    input  logic [PW-1:0] BrOffset,
    output logic          FetchStart,
    output logic          BranchAbs,
    output logic          BranchRelEn,
    output logic          ALU_flag,
    output logic [PW-1:0] Target,
    output logic          Flush,
    output logic          Running,
    output logic          Done,
    output logic          Timeout,
    output logic [CW-1:0] RetireCnt
);

    seq_state_e state_q, state_d;
    logic       flush_q, flush_d;
    logic       done_q, done_d;
    logic       timeout_q, timeout_d;

    logic       active;
    logic       taken;
    logic       wd_clr;
    logic       wd_en;
    logic       wd_tc;

    // A flushed slot is never an active instruction, so it can neither
    // branch nor halt; this is also what keeps Flush from chaining.
    assign active = (state_q == RUN) && !flush_q;

    // Branch gating. Halt on the same active instruction suppresses the
    // branch entirely.
    always_comb begin
        BranchAbs   = 1'b0;
        BranchRelEn = 1'b0;
        ALU_flag    = 1'b0;
        Target      = '0;
        if (active && !Halt) begin
            case (br_op_e'(BrOp))
                BR_ABS: begin
                    BranchAbs = 1'b1;
                    Target    = BrOffset;
                end
                BR_REL_COND: begin
                    BranchRelEn = 1'b1;
                    ALU_flag    = CondFlag;
                    Target      = BrOffset;
                end
                BR_REL_UNCOND: begin
                    BranchRelEn = 1'b1;
                    ALU_flag    = 1'b1;
                    Target      = BrOffset;
                end
                default: ;
            endcase
        end
    end

    assign taken = BranchAbs | (BranchRelEn & ALU_flag);

    // Next-state logic. Halt is checked before the watchdog so a halt in
    // the terminal cycle still completes normally.
    always_comb begin
        state_d   = state_q;
        done_d    = done_q;
        timeout_d = timeout_q;
        wd_clr    = 1'b0;
        case (state_q)
            IDLE, DONE, FAULT: begin
                if (Start) begin
                    state_d   = LOAD;
                    done_d    = 1'b0;
                    timeout_d = 1'b0;
                    wd_clr    = 1'b1;
                end
            end
            LOAD: begin
                state_d = RUN;
            end
            RUN: begin
                if (active && Halt) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else if (wd_tc) begin
                    state_d   = FAULT;
                    timeout_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // A bubble only matters if the run continues into the next cycle.
        flush_d = taken && (state_d == RUN);
    end

    // State, Flush and sticky status registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= IDLE;
            flush_q   <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            flush_q   <= flush_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
        end
    end

    // The watchdog counts every RUN cycle, flushed or not.
    assign wd_en = (state_q == RUN);

    run_watchdog #(
        .CW         (CW),
        .MAX_CYCLES (MAX_CYCLES)
    ) u_run_watchdog (
        .clk (Clk),
        .rst (Reset),
        .clr (wd_clr),
        .en  (wd_en),
        .tc  (wd_tc)
    );

`ifdef RETIRE_COUNT_EN
    logic [CW-1:0] retire_cnt_q;
    logic [CW-1:0] retire_cnt_d;

    // Retired-instruction count: cleared on the Start edge, saturating,
    // and naturally held outside RUN because only active cycles step it.
    always_comb begin
        retire_cnt_d = retire_cnt_q;
        if (wd_clr) begin
            retire_cnt_d = '0;
        end else if (active && (retire_cnt_q != '1)) begin
            retire_cnt_d = retire_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            retire_cnt_q <= '0;
        end else begin
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign RetireCnt = retire_cnt_q;
`else
    assign RetireCnt = '0;
`endif

    assign FetchStart = (state_q == LOAD);
    assign Running    = (state_q == RUN);
    assign Flush      = flush_q;
    assign Done       = done_q;
    assign Timeout    = timeout_q;

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Program-run controller for the instruction fetch unit. It turns a single Start request into the fetch unit's PC-load pulse and gates decoded branch requests into the fetch unit's BranchAbs / BranchRelEn / ALU_flag / Target controls. It inserts a one-cycle flush bubble after every taken branch and stops the run on a halt or a watchdog timeout. It sits between the decoder/ALU and the fetch unit, and drives the top-level Done.

Parameters:
PW, 10, program counter / branch target width
MAX_CYCLES, 1023, watchdog limit on RUN cycles before a fault
CW, 16, width of the watchdog and retire counters

Ports:
Clk  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-high reset
Start  input  1  run request; sampled in IDLE, DONE or FAULT
Halt  input  1  decoded halt instruction at the current PC
BrOp  input  2  branch type: 00 none, 01 absolute, 10 relative-conditional, 11 relative-unconditional
CondFlag  input  1  ALU condition flag for relative-conditional branches
BrOffset  input  PW  absolute target or two's-complement relative offset
FetchStart  output  1  fetch-unit Start; forces PC to 0
BranchAbs  output  1  fetch-unit absolute branch
BranchRelEn  output  1  fetch-unit relative branch enable
ALU_flag  output  1  fetch-unit relative-branch qualifier
Target  output  PW  fetch-unit target/offset
Flush  output  1  current instruction is a bubble; downstream must squash it
Running  output  1  state is RUN
Done  output  1  sticky normal completion
Timeout  output  1  sticky watchdog fault
RetireCnt  output  CW  count of retired (non-flushed) RUN instructions

Behaviour:
- States: IDLE, LOAD, RUN, DONE, FAULT.
- Reset (async): state IDLE. All outputs 0, including Flush and both counters.
- IDLE/DONE/FAULT, Start=1 -> LOAD at the next edge. Done, Timeout, watchdog and RetireCnt clear at that same edge. Otherwise stay in the current state.
- LOAD: FetchStart=1 for exactly one cycle -> RUN.
- Start while in LOAD or RUN is ignored.
- Active instruction = RUN & !Flush. Branch outputs are combinational and asserted only for an active instruction:
  - BrOp=01: BranchAbs=1, Target=BrOffset.
  - BrOp=10: BranchRelEn=1, ALU_flag=CondFlag, Target=BrOffset.
  - BrOp=11: BranchRelEn=1, ALU_flag=1, Target=BrOffset.
  - Otherwise all three outputs are 0 and Target=0.
- Taken = BranchAbs | (BranchRelEn & ALU_flag). A taken branch sets the Flush register for the next cycle only. Flush never chains, because a flushed instruction cannot itself be taken.
- Halt on an active instruction -> DONE at the next edge, with Done=1. Halt while Flush=1 is ignored. If Halt and a branch occur together, Halt wins: no branch outputs are asserted that cycle.
- Watchdog: counts every RUN cycle, including flushed ones.
  - When the count equals MAX_CYCLES-1 and no active Halt is present -> FAULT at the next edge, with Timeout=1.
  - Halt in that same cycle -> DONE; halt beats timeout.
- Done and Timeout are registered, mutually exclusive, and held until Start or Reset.
- Running=1 exactly in RUN.
- Reset asserted mid-run returns to IDLE immediately. No pending Flush survives the reset.

Optional Feature:
RETIRE_COUNT_EN
- Defined: RetireCnt increments on each active RUN cycle. It saturates at all-ones, clears when entering LOAD, and holds its value in DONE/FAULT.
- Undefined: the counter logic is omitted and RetireCnt is tied to 0.

Decomposition:
- Package fetch_seq_pkg holds:
  - state enum: IDLE, LOAD, RUN, DONE, FAULT
  - BrOp encoding enum: BR_NONE, BR_ABS, BR_REL_COND, BR_REL_UNCOND
  - default PW and CW constants
- One sub-module, run_watchdog:
  - CW-bit counter with clear and enable.
  - Terminal-count output compared against MAX_CYCLES-1.
- The FSM, branch gating and Flush logic stay in fetch_sequencer.

Test Plan:
1. Reset held 20ns, then Start pulse -> FetchStart=1 for exactly one cycle, Running=1 from the next cycle, and all branch outputs 0 while BrOp=00.
2. RUN, BrOp=01, BrOffset=0 -> BranchAbs=1, Target=0, Flush=1 the next cycle. With BrOp=01 still held during Flush, BranchAbs=0.
3. RUN, BrOp=10, BrOffset=10'h3FC, CondFlag=0 then 1 -> BranchRelEn=1 both cycles. ALU_flag follows CondFlag, and Flush=1 only after the CondFlag=1 cycle.
4. Halt and BrOp=11 in the same active cycle -> no branch outputs, DONE next cycle with Done=1. A later Start clears Done and pulses FetchStart.
5. MAX_CYCLES=8 with no halt -> FAULT after 8 RUN cycles, Timeout=1, Done=0. Repeat with Halt on the 8th cycle -> Done=1, Timeout=0.
6. Reset asserted mid-RUN, one cycle after a taken branch -> outputs 0 and Flush=0 immediately. With RETIRE_COUNT_EN defined, RetireCnt equals the number of non-flushed cycles before the halt (e.g. 5 for 6 RUN cycles with one flush).
